// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared state encoding, parameter defaults and width helper for spi_sched
package spi_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    localparam int NUM_REQ_DEF       = 4;
    localparam int FRAME_W_DEF       = 40;
    localparam int CS_W_DEF          = 4;
    localparam int START_TIMEOUT_DEF = 255;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_sched_if.sv
// spi_sched_if: requester and SPI-master signals of spi_sched
// master: scheduler side (drives req_ready, rsp_*, spi_data, spi_cs_select, spi_send_en, busy)
// slave: environment side (drives req_valid, req_frame, req_cs, spi_ready_in, spi_data_in)
interface spi_sched_if import spi_sched_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CS_W    = CS_W_DEF
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*FRAME_W-1:0] req_frame;
    logic [NUM_REQ*CS_W-1:0]    req_cs;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [FRAME_W-1:0]         rsp_data;
    logic                       rsp_timeout;
    logic [FRAME_W-1:0]         spi_data;
    logic [CS_W-1:0]            spi_cs_select;
    logic                       spi_send_en;
    logic                       spi_ready_in;
    logic [FRAME_W-1:0]         spi_data_in;
    logic                       busy;
    modport master (
        input  req_valid, req_frame, req_cs, spi_ready_in, spi_data_in,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, spi_data, spi_cs_select, spi_send_en, busy
    );
    modport slave (
        output req_valid, req_frame, req_cs, spi_ready_in, spi_data_in,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, spi_data, spi_cs_select, spi_send_en, busy
    );
endinterface

// File: rtl/spi_sched_rr_arbiter.sv
// rr_arbiter: picks the first requesting index after last_grant, wrapping modulo NUM_REQ
// req: request vector; last_grant: previous winner; gnt: winning index; any: some request present
module rr_arbiter import spi_sched_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      gnt,
    output logic               any
);
    logic [IW-1:0] j;
    assign any = |req;
    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        gnt = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(last_grant) + k) % NUM_REQ);
            gnt = req[j] ? j : gnt;
        end
    end
endmodule

// File: rtl/spi_sched.sv
// spi_sched: round-robin scheduler sharing one SPI master among NUM_REQ requesters
// clk_in/reset_in: clock and synchronous active-high reset
// bus (master modport): request/response handshake and SPI master control/data
module spi_sched import spi_sched_pkg::*; #(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int FRAME_W       = FRAME_W_DEF,
    parameter int CS_W          = CS_W_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input logic       clk_in,
    input logic       reset_in,
    spi_sched_if.master bus
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);
    state_t        state, state_nx;
    logic [IW-1:0] gnt, owner, last_grant;
    logic [CW-1:0] cnt;
    logic          any, grant, tmo, timeout_hit;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(bus.req_valid),
        .last_grant(last_grant),
        .gnt(gnt),
        .any(any)
    );
    // Reset gates the grant so no acceptance pulse escapes during reset.
    assign grant = state == IDLE && any && bus.spi_ready_in && !reset_in;
    assign timeout_hit = cnt == CW'(START_TIMEOUT);
    always_ff @(posedge clk_in) begin
        state <= reset_in ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? START : IDLE;
            START:   state_nx = !bus.spi_ready_in ? WAIT : (timeout_hit ? DONE : START);
            WAIT:    state_nx = bus.spi_ready_in ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        bus.req_ready   = grant ? NUM_REQ'(1) << gnt : '0;
        bus.rsp_valid   = state == DONE ? NUM_REQ'(1) << owner : '0;
        bus.rsp_timeout = state == DONE && tmo;
        bus.spi_send_en = state == START;
        bus.busy        = state != IDLE;
    end
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            owner             <= '0;
            last_grant        <= IW'(NUM_REQ - 1);
            cnt               <= '0;
            tmo               <= 1'b0;
            bus.rsp_data      <= '0;
            bus.spi_data      <= '0;
            bus.spi_cs_select <= '0;
        end else begin
            if (grant) begin
                owner             <= gnt;
                cnt               <= '0;
                tmo               <= 1'b0;
                bus.spi_data      <= bus.req_frame[int'(gnt) * FRAME_W +: FRAME_W];
                bus.spi_cs_select <= bus.req_cs[int'(gnt) * CS_W +: CS_W];
            end
            if (state == START && bus.spi_ready_in) begin
                cnt          <= timeout_hit ? cnt : cnt + 1'b1;
                tmo          <= timeout_hit;
                bus.rsp_data <= timeout_hit ? '0 : bus.rsp_data;
            end
            if (state == WAIT && bus.spi_ready_in)
                bus.rsp_data <= bus.spi_data_in;
            if (state == DONE)
                last_grant <= owner;
        end
    end
endmodule

// File: tb/tb_spi_sched.sv
// tb_spi_sched: directed and randomized transfers checked against a round-robin reference model
module tb_spi_sched;
    localparam int N   = 4;
    localparam int FW  = 40;
    localparam int CSW = 4;
    localparam int TO  = 255;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    int last;
    logic [FW-1:0]  frames[N];
    logic [CSW-1:0] css[N];
    spi_sched_if #(.NUM_REQ(N), .FRAME_W(FW), .CS_W(CSW)) bus ();
    spi_sched #(.NUM_REQ(N), .FRAME_W(FW), .CS_W(CSW), .START_TIMEOUT(TO)) dut (
        .clk_in(clk),
        .reset_in(rst),
        .bus(bus)
    );
    always #20 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int rr_pick(input logic [N-1:0] v, input int prev);
        for (int k = 1; k <= N; k++)
            if (v[(prev + k) % N]) return (prev + k) % N;
        return -1;
    endfunction
    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction
    task automatic pack();
        for (int i = 0; i < N; i++) begin
            bus.req_frame[i*FW +: FW] = frames[i];
            bus.req_cs[i*CSW +: CSW]  = css[i];
        end
    endtask
    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            frames[i] = FW'({$urandom, $urandom});
            css[i]    = CSW'($urandom);
        end
        pack();
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_spi_data"}, bus.spi_data, 0);
        chk({tag, "_cs"}, bus.spi_cs_select, 0);
        chk({tag, "_send_en"}, bus.spi_send_en, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask
    // Starts and ends on a falling edge with the DUT idle. d = extra START cycles before the
    // master goes busy, lat = busy cycles, hold = IDLE cycles with the master not ready.
    task automatic xfer(input logic [N-1:0] v, input int hold, input int d, input int lat,
                        input bit tmo, input bit echo);
        int g;
        logic [FW-1:0]  ef, resp;
        logic [CSW-1:0] ec;
        bus.req_valid = v;
        bus.spi_ready_in = hold == 0;
        #1;
        chk("idle_busy", bus.busy, 0);
        for (int i = 0; i < hold; i++) begin
            chk("held_off_ready", bus.req_ready, 0);
            @(negedge clk);
            chk("held_off_busy", bus.busy, 0);
        end
        bus.spi_ready_in = 1'b1;
        #1;
        g = rr_pick(v, last);
        ef = frames[g];
        ec = css[g];
        chk("req_ready", bus.req_ready, oh(g));
        @(negedge clk);
        chk("start_send_en", bus.spi_send_en, 1);
        chk("start_spi_data", bus.spi_data, ef);
        chk("start_cs", bus.spi_cs_select, ec);
        chk("start_busy", bus.busy, 1);
        chk("start_req_ready", bus.req_ready, 0);
        scramble();
        resp = '0;
        if (tmo) begin
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                chk("tmo_start_hold", {bus.spi_send_en, bus.rsp_valid}, {1'b1, {N{1'b0}}});
            end
        end else begin
            for (int k = 0; k < d; k++) @(negedge clk);
            bus.spi_ready_in = 1'b0;
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                chk("wait_send_en", bus.spi_send_en, 0);
                chk("wait_rsp_valid", bus.rsp_valid, 0);
                chk("wait_spi_data", bus.spi_data, ef);
            end
            resp = echo ? ef : FW'({$urandom, $urandom});
            bus.spi_data_in = resp;
            bus.spi_ready_in = 1'b1;
        end
        @(negedge clk);
        chk("done_rsp_valid", bus.rsp_valid, oh(g));
        chk("done_rsp_timeout", bus.rsp_timeout, tmo);
        chk("done_rsp_data", bus.rsp_data, resp);
        chk("done_cs", bus.spi_cs_select, ec);
        last = g;
        @(negedge clk);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_after_busy", bus.busy, 0);
        chk("idle_spi_data_kept", bus.spi_data, ef);
        chk("idle_cs_kept", bus.spi_cs_select, ec);
    endtask
    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.spi_ready_in = 1'b1;
        bus.spi_data_in = '0;
        scramble();
        last = N - 1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scramble();
            xfer('1, 0, 1, 3 + i, 1'b0, 1'b0);
        end
        frames[0] = 40'h12_3456789A;
        css[0] = 4'd3;
        pack();
        xfer(4'b0001, 0, 0, 10, 1'b0, 1'b1);
        scramble();
        xfer(4'b0010, 5, 0, 4, 1'b0, 1'b0);
        scramble();
        xfer(4'b0100, 0, 0, 0, 1'b1, 1'b0);
        scramble();
        bus.req_valid = 4'b0001;
        bus.spi_ready_in = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 4'b0001);
        @(negedge clk);
        chk("rst_start", bus.spi_send_en, 1);
        bus.spi_ready_in = 1'b0;
        @(negedge clk);
        chk("rst_wait_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        rst = 1'b0;
        last = N - 1;
        bus.req_valid = '0;
        bus.spi_ready_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", bus.rsp_valid, 0);
            chk("post_reset_busy", bus.busy, 0);
        end
        xfer(4'b1001, 0, 0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            scramble();
            xfer(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(1, 12), 1'b0, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
